prog_loader: RTL and testbench

Serial program loader that receives a length-prefixed memory image over an 8N1 UART line and produces the program-load write stream for the core's memories: 32-bit data-memory word writes and 128-bit instruction-memory line writes. It sits at the top level beside the pipeline and drives the `prog_loadaddr` / `prog_loaddata` / `prog_dmem_we` / `prog_imem_we` nets. It asserts `done` once the image is fully written, which releases the core from program-loading mode.

---
 rtl/prog_loader_pkg.sv | 15 +
 rtl/prog_loader_if.sv | 16 +
 rtl/prog_loader_uart_rx.sv | 87 ++++++++
 rtl/prog_loader.sv | 127 ++++++++++++
 tb/tb_prog_loader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

  typedef enum logic [1:0] {StHdr, StLoad, StDone} load_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned WORD_BYTES = 4;

  // Image length rounded down to whole imem lines.
  function automatic logic [31:0] line_len(input logic [31:0] len);
    return len & ~32'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Program-load write bus from the loader to the core memories.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_LEN = 32
);
  logic [ADDR_LEN-1:0]     addr;
  logic [8*LINE_BYTES-1:0] data;
  logic                    we_32;
  logic                    we_128;
  logic                    done;
  logic                    err;

  modport master (output addr, data, we_32, we_128, done, err);
  modport slave  (input  addr, data, we_32, we_128, done, err);
endinterface

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, bit timer and RX FSM.
module prog_loader_uart_rx
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]      sync_q;
  logic            rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_s;

  assign rx_s      = sync_q[1];
  assign byte_data = shift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CntW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) state_d = RxStart;
      end
      RxStart: begin
        // A start bit that is high again at mid-bit is a glitch.
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q == BitLast) begin
          cnt_d      = '0;
          state_d    = RxIdle;
          byte_valid = rx_s;
          frame_err  = !rx_s;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: length-prefixed UART image to dmem word / imem line write strobes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_LEN     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rxd,
  prog_loader_if.master bus
);
  localparam int unsigned WordLsb = $clog2(WORD_BYTES);
  localparam int unsigned LineLsb = $clog2(LINE_BYTES);
  localparam int unsigned DataW   = 8 * LINE_BYTES;

  logic       rx_valid, rx_err;
  logic [7:0] rx_data;

  prog_loader_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .frame_err (rx_err)
  );

  load_state_e         state_q, state_d;
  logic [31:0]         len_q, len_d;
  logic [1:0]          hdr_cnt_q, hdr_cnt_d;
  logic [ADDR_LEN-1:0] count_q, count_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [DataW-1:0]    data_q, data_d;
  logic                we32_q, we32_d, we128_q, we128_d;
  logic                done_q, done_d, err_q, err_d;
  logic [31:0]         len_n;
  logic [ADDR_LEN-1:0] cnt_n, tgt;

  assign len_n = {rx_data, len_q[31:8]};
  assign cnt_n = count_q + ADDR_LEN'(1);
  assign tgt   = ADDR_LEN'(line_len(len_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StHdr;
      len_q     <= '0;
      hdr_cnt_q <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we32_q    <= 1'b0;
      we128_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hdr_cnt_q <= hdr_cnt_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we32_q    <= we32_d;
      we128_q   <= we128_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hdr_cnt_d = hdr_cnt_q;
    count_d   = count_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we32_d    = 1'b0;
    we128_d   = 1'b0;
    done_d    = done_q;
    err_d     = err_q | rx_err;
    unique case (state_q)
      StHdr: begin
        if (rx_valid) begin
          len_d     = len_n;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            count_d = '0;
            if (line_len(len_n) == 32'd0) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StLoad;
            end
          end
        end
      end
      StLoad: begin
        if (rx_valid) begin
          data_d  = {rx_data, data_q[DataW-1:8]};
          count_d = cnt_n;
          // addr names the word just completed, i.e. line base + 12 on a line strobe.
          if (cnt_n[WordLsb-1:0] == '0) begin
            we32_d = 1'b1;
            addr_d = cnt_n - ADDR_LEN'(WORD_BYTES);
          end
          if (cnt_n[LineLsb-1:0] == '0) we128_d = 1'b1;
          if (cnt_n == tgt) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StHdr;
    endcase
  end

  assign bus.addr   = addr_q;
  assign bus.data   = data_q;
  assign bus.we_32  = we32_q;
  assign bus.we_128 = we128_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a strobe scoreboard built from the image bytes.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int CPB = 4;
  localparam int AW  = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic        done;
  } exp32_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         done;
  } exp128_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rxd   = 1'b1;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_LEN(AW)) bus ();

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_LEN    (AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rxd  (rxd),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n32      = 0;
  int n128     = 0;
  int bv_cnt   = 0;
  int last_bv_cyc   = -1;
  int done_rise_cyc = -1;
  logic done_prev   = 1'b0;

  logic [7:0] img_q[$];
  exp32_t     exp32_q[$];
  exp128_t    exp128_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation of its kind.
  always @(negedge clk) begin
    cyc++;
    if (dut.rx_valid) begin
      bv_cnt++;
      last_bv_cyc = cyc;
    end
    if (bus.done && !done_prev) done_rise_cyc = cyc;
    done_prev = bus.done;
    if (bus.we_32) begin
      n32++;
      check("we32_expected", 128'(exp32_q.size() != 0), 128'(1));
      if (exp32_q.size() != 0) begin
        exp32_t e;
        e = exp32_q.pop_front();
        check("we32_addr", 128'(bus.addr), 128'(e.addr));
        check("we32_word", 128'(bus.data[127:96]), 128'(e.word));
        check("we32_done", 128'(bus.done), 128'(e.done));
      end
    end
    if (bus.we_128) begin
      n128++;
      check("we128_expected", 128'(exp128_q.size() != 0), 128'(1));
      if (exp128_q.size() != 0) begin
        exp128_t e;
        e = exp128_q.pop_front();
        check("we128_addr", 128'(bus.addr), 128'(e.addr));
        check("we128_data", bus.data, e.data);
        check("we128_done", 128'(bus.done), 128'(e.done));
      end
    end
  end

  // Expected strobes for the bytes in img_q, as the loader should accept them.
  task automatic push_expect(input int len);
    int tgt, lim;
    tgt = len & ~32'hF;
    lim = (img_q.size() < tgt) ? img_q.size() : tgt;
    for (int w = 0; 4 * w + 4 <= lim; w++) begin
      exp32_t e;
      e.addr = 32'(4 * w);
      e.word = {img_q[4*w+3], img_q[4*w+2], img_q[4*w+1], img_q[4*w]};
      e.done = (4 * w + 4 == tgt);
      exp32_q.push_back(e);
    end
    for (int l = 0; 16 * l + 16 <= lim; l++) begin
      exp128_t e;
      e.addr = 32'(16 * l + 12);
      for (int k = 0; k < 16; k++) e.data[8*k +: 8] = img_q[16*l+k];
      e.done = (16 * l + 16 == tgt);
      exp128_q.push_back(e);
    end
  endtask

  task automatic bit_out(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    rxd = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_len(input logic [31:0] len);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b1);
  endtask

  task automatic send_img();
    for (int i = 0; i < img_q.size(); i++) send_byte(img_q[i], 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, 128'(bus.addr), 128'(0));
    check({tag, "_data"}, bus.data, 128'(0));
    check({tag, "_we32"}, 128'(bus.we_32), 128'(0));
    check({tag, "_we128"}, 128'(bus.we_128), 128'(0));
    check({tag, "_done"}, 128'(bus.done), 128'(0));
    check({tag, "_err"}, 128'(bus.err), 128'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rxd   = 1'b1;
    img_q.delete();
    exp32_q.delete();
    exp128_q.delete();
    idle(3);
    reset = 1'b0;
    idle(2);
    n32  = 0;
    n128 = 0;
  endtask

  task automatic end_checks(input string tag, input logic done, input logic err,
                            input int e32, input int e128);
    check({tag, "_q32_empty"}, 128'(exp32_q.size()), 128'(0));
    check({tag, "_q128_empty"}, 128'(exp128_q.size()), 128'(0));
    check({tag, "_n32"}, 128'(n32), 128'(e32));
    check({tag, "_n128"}, 128'(n128), 128'(e128));
    check({tag, "_done"}, 128'(bus.done), 128'(done));
    check({tag, "_err"}, 128'(bus.err), 128'(err));
  endtask

  initial begin
    int bv0, rise_exp;
    idle(2);
    check_zero("reset");
    do_reset();

    // Single line of 16 bytes.
    for (int i = 0; i < 16; i++) img_q.push_back(8'(i));
    push_expect(16);
    send_len(32'd16);
    send_img();
    idle(8);
    end_checks("single", 1'b1, 1'b0, 4, 1);
    check("single_hold_addr", 128'(bus.addr), 128'(32'hC));
    check("single_hold_data", bus.data, 128'h0F0E0D0C0B0A09080706050403020100);

    // One-cycle glitch on idle line.
    do_reset();
    bv0 = bv_cnt;
    rxd = 1'b0;
    idle(1);
    rxd = 1'b1;
    idle(6 * CPB);
    check("glitch_no_byte", 128'(bv_cnt), 128'(bv0));
    check("glitch_err", 128'(bus.err), 128'(0));

    // Zero length header.
    do_reset();
    done_rise_cyc = -1;
    send_len(32'd0);
    idle(4);
    rise_exp = last_bv_cyc + 1;
    check("zero_done_timing", 128'(done_rise_cyc), 128'(rise_exp));
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    idle(4);
    end_checks("zero", 1'b1, 1'b0, 0, 0);

    // Length 0x23 truncated to 32; 40 bytes sent.
    do_reset();
    for (int i = 0; i < 40; i++) img_q.push_back(8'(3 * i + 1));
    push_expect(32'h23);
    send_len(32'h23);
    send_img();
    idle(8);
    end_checks("trunc", 1'b1, 1'b0, 8, 2);
    check("trunc_final_addr", 128'(bus.addr), 128'(32'h1C));

    // Framing error on image byte 5: later bytes shift down by one.
    do_reset();
    for (int i = 0; i < 17; i++) if (i != 5) img_q.push_back(8'(i));
    push_expect(16);
    send_len(32'd16);
    for (int i = 0; i < 17; i++) send_byte(8'(i), (i != 5));
    idle(8);
    end_checks("framing", 1'b1, 1'b1, 4, 1);

    // Reset part way through a 32-byte image, then a clean resend.
    do_reset();
    for (int i = 0; i < 20; i++) img_q.push_back(8'(8'h40 + i));
    push_expect(32);
    send_len(32'd32);
    send_img();
    idle(4);
    end_checks("partial", 1'b0, 1'b0, 5, 1);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    idle(2);
    reset = 1'b0;
    idle(2);
    n32  = 0;
    n128 = 0;
    img_q.delete();
    for (int i = 0; i < 16; i++) img_q.push_back(8'(8'hA0 + i));
    push_expect(16);
    send_len(32'd16);
    send_img();
    idle(8);
    end_checks("resend", 1'b1, 1'b0, 4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
